// File: rtl/neo_pixel_receiver.sv
// NeoPixel (WS2812-style) serial line receiver: pulse-width decoding into 24-bit
// LSB-first pixel words, with frame-latch detection and timing-error tracking.
module neo_pixel_receiver #(
  parameter int NUM_PIXELS   = 5,
  parameter int BIT_THRESH   = 27,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 50,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_neo_in,
  output logic [23:0] o_pixel_data,
  output logic [2:0]  o_pixel_index,
  output logic        o_pixel_valid,
  output logic        o_frame_done,
  output logic [3:0]  o_frame_pixels,
  output logic        o_frame_err,
  output logic        o_timing_err,
  output logic        o_busy
);

  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int HW = $clog2(MAX_HIGH + 1);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW, S_ERROR} state_t;

  state_t         r_state;
  logic           r_sync1;
  logic           r_sin;
  logic           r_sin_d;
  logic [LW-1:0]  r_low_cnt;
  logic [HW-1:0]  r_high_cnt;
  logic [4:0]     r_bit_cnt;
  logic [3:0]     r_pix_cnt;
  logic [23:0]    r_shift;
  logic           r_overflow;

  logic           w_rise;
  logic           w_bit;
  logic [23:0]    w_word;
  logic [LW-1:0]  w_low_next;
  logic [HW-1:0]  w_high_next;
  logic           w_latched;

  assign w_rise      = r_sin & ~r_sin_d;
  assign w_bit       = (r_high_cnt >= HW'(BIT_THRESH));
  assign w_word      = {w_bit, r_shift[23:1]};
  assign w_low_next  = r_low_cnt + LW'(1);
  assign w_high_next = r_high_cnt + HW'(1);
  // w_low_next is the number of consecutive low cycles including the current one
  assign w_latched   = (w_low_next >= LW'(LATCH_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_SYNC;
      r_sync1        <= 1'b0;
      r_sin          <= 1'b0;
      r_sin_d        <= 1'b0;
      r_low_cnt      <= '0;
      r_high_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_pix_cnt      <= '0;
      r_shift        <= '0;
      r_overflow     <= 1'b0;
      o_pixel_data   <= '0;
      o_pixel_index  <= '0;
      o_pixel_valid  <= 1'b0;
      o_frame_done   <= 1'b0;
      o_frame_pixels <= '0;
      o_frame_err    <= 1'b0;
      o_timing_err   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      r_sync1       <= i_neo_in;
      r_sin         <= r_sync1;
      r_sin_d       <= r_sin;
      o_pixel_valid <= 1'b0;
      o_frame_done  <= 1'b0;

      unique case (r_state)
        S_SYNC, S_ERROR: begin
          if (r_sin) begin
            r_low_cnt <= '0;
          end else if (w_latched) begin
            r_low_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_low_cnt <= w_low_next;
          end
        end

        S_IDLE: begin
          if (w_rise) begin
            r_high_cnt   <= HW'(1);
            r_bit_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_overflow   <= 1'b0;
            o_timing_err <= 1'b0;
            o_busy       <= 1'b1;
            r_state      <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (r_sin) begin
            if (w_high_next >= HW'(MAX_HIGH)) begin
              o_timing_err <= 1'b1;
              o_busy       <= 1'b0;
              r_low_cnt    <= '0;
              r_state      <= S_ERROR;
            end else begin
              r_high_cnt <= w_high_next;
            end
          end else if (r_high_cnt < HW'(MIN_HIGH)) begin
            o_timing_err <= 1'b1;
            o_busy       <= 1'b0;
            r_low_cnt    <= '0;
            r_state      <= S_ERROR;
          end else begin
            r_shift   <= w_word;
            r_low_cnt <= LW'(1);
            r_state   <= S_LOW;
            if (r_bit_cnt == 5'd23) begin
              r_bit_cnt <= '0;
              // pixel count saturates at NUM_PIXELS; anything beyond is overflow
              if (r_pix_cnt < 4'(NUM_PIXELS)) begin
                o_pixel_data  <= w_word;
                o_pixel_index <= r_pix_cnt[2:0];
                o_pixel_valid <= 1'b1;
                r_pix_cnt     <= r_pix_cnt + 4'd1;
              end else begin
                r_overflow <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end

        S_LOW: begin
          if (r_sin) begin
            r_high_cnt <= HW'(1);
            r_state    <= S_HIGH;
          end else if (w_latched) begin
            o_frame_done   <= 1'b1;
            o_frame_pixels <= r_pix_cnt;
            o_frame_err    <= (r_bit_cnt != 5'd0) | r_overflow;
            o_busy         <= 1'b0;
            r_low_cnt      <= '0;
            r_state        <= S_IDLE;
          end else begin
            r_low_cnt <= w_low_next;
          end
        end

        default: r_state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// Directed bench for neo_pixel_receiver: drives pulse-width encoded frames and
// checks strobes, frame summaries and error flags against hand-computed values.
module tb_neo_pixel_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        neo = 1'b0;
  logic [23:0] pixel_data;
  logic [2:0]  pixel_index;
  logic        pixel_valid;
  logic        frame_done;
  logic [3:0]  frame_pixels;
  logic        frame_err;
  logic        timing_err;
  logic        busy;

  neo_pixel_receiver #(
    .NUM_PIXELS  (5),
    .BIT_THRESH  (27),
    .MIN_HIGH    (8),
    .MAX_HIGH    (50),
    .LATCH_CYCLES(2500)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_neo_in      (neo),
    .o_pixel_data  (pixel_data),
    .o_pixel_index (pixel_index),
    .o_pixel_valid (pixel_valid),
    .o_frame_done  (frame_done),
    .o_frame_pixels(frame_pixels),
    .o_frame_err   (frame_err),
    .o_timing_err  (timing_err),
    .o_busy        (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [23:0] pv_data[$];
  logic [2:0]  pv_idx[$];
  logic [3:0]  fd_pix[$];
  logic        fd_err[$];

  // strobes are single-cycle, so they are recorded as they occur
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_data.push_back(pixel_data);
      pv_idx.push_back(pixel_index);
    end
    if (frame_done) begin
      fd_pix.push_back(frame_pixels);
      fd_err.push_back(frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pv_data_at(input int k);
    if (k < pv_data.size()) return pv_data[k];
    return 'x;
  endfunction

  function automatic logic [2:0] pv_idx_at(input int k);
    if (k < pv_idx.size()) return pv_idx[k];
    return 'x;
  endfunction

  function automatic logic [3:0] fd_pix_at(input int k);
    if (k < fd_pix.size()) return fd_pix[k];
    return 'x;
  endfunction

  function automatic logic fd_err_at(input int k);
    if (k < fd_err.size()) return fd_err[k];
    return 1'bx;
  endfunction

  task automatic idle(input int n);
    neo = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int h, input int l);
    neo = 1'b1;
    repeat (h) @(negedge clk);
    neo = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] d);
    for (int i = 0; i < 24; i++) begin
      if (d[i]) send_bit(35, 30);
      else      send_bit(18, 40);
    end
  endtask

  logic [23:0] px [6];
  int pv_base;
  int fd_base;

  initial begin
    px[0] = 24'h123456;
    px[1] = 24'hABCDEF;
    px[2] = 24'h000001;
    px[3] = 24'h800000;
    px[4] = 24'hFFFFFF;
    px[5] = 24'h0F0F0F;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(pixel_data), 32'h0);
    check("rst_valid", 32'(pixel_valid), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(2510);

    // single pixel 0x00FF81
    pv_base = pv_data.size();
    fd_base = fd_pix.size();
    send_pixel(24'h00FF81);
    idle(2510);
    check("t1_strobes", 32'(pv_data.size() - pv_base), 32'd1);
    check("t1_data", 32'(pv_data_at(pv_base)), 32'h00FF81);
    check("t1_index", 32'(pv_idx_at(pv_base)), 32'd0);
    check("t1_frames", 32'(fd_pix.size() - fd_base), 32'd1);
    check("t1_frame_pixels", 32'(fd_pix_at(fd_base)), 32'd1);
    check("t1_frame_err", 32'(fd_err_at(fd_base)), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // five-pixel frame
    pv_base = pv_data.size();
    fd_base = fd_pix.size();
    send_pixel(px[0]);
    check("t2_busy_mid", 32'(busy), 32'd1);
    for (int p = 1; p < 5; p++) send_pixel(px[p]);
    idle(2510);
    check("t2_strobes", 32'(pv_data.size() - pv_base), 32'd5);
    for (int p = 0; p < 5; p++) begin
      check($sformatf("t2_data%0d", p), 32'(pv_data_at(pv_base + p)), 32'(px[p]));
      check($sformatf("t2_index%0d", p), 32'(pv_idx_at(pv_base + p)), 32'(p));
    end
    check("t2_frame_pixels", 32'(fd_pix_at(fd_base)), 32'd5);
    check("t2_frame_err", 32'(fd_err_at(fd_base)), 32'd0);

    // threshold: 26 high -> 0, 27 high -> 1
    pv_base = pv_data.size();
    send_bit(26, 40);
    send_bit(27, 40);
    for (int i = 2; i < 24; i++) send_bit(18, 40);
    idle(2510);
    check("t3_strobes", 32'(pv_data.size() - pv_base), 32'd1);
    check("t3_data", 32'(pv_data_at(pv_base)), 32'h000002);
    idle(20);
    check("t3_data_hold", 32'(pixel_data), 32'h000002);

    // 5-cycle runt pulse mid-pixel
    pv_base = pv_data.size();
    fd_base = fd_pix.size();
    for (int i = 0; i < 5; i++) send_bit(35, 30);
    send_bit(5, 20);
    check("t4_timing_err", 32'(timing_err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    idle(2600);
    check("t4_no_frame", 32'(fd_pix.size() - fd_base), 32'd0);
    check("t4_no_strobe", 32'(pv_data.size() - pv_base), 32'd0);
    send_pixel(24'hA5A5A5);
    idle(2510);
    check("t4_recover_data", 32'(pv_data_at(pv_base)), 32'hA5A5A5);
    check("t4_recover_index", 32'(pv_idx_at(pv_base)), 32'd0);
    check("t4_recover_pixels", 32'(fd_pix_at(fd_base)), 32'd1);
    check("t4_recover_err", 32'(fd_err_at(fd_base)), 32'd0);
    check("t4_timing_err_clr", 32'(timing_err), 32'd0);

    // six pixels plus ten bits: overflow and partial pixel
    pv_base = pv_data.size();
    fd_base = fd_pix.size();
    for (int p = 0; p < 6; p++) send_pixel(px[p]);
    for (int i = 0; i < 10; i++) send_bit(35, 30);
    idle(2510);
    check("t5_strobes", 32'(pv_data.size() - pv_base), 32'd5);
    check("t5_last_index", 32'(pv_idx_at(pv_base + 4)), 32'd4);
    check("t5_data_held", 32'(pixel_data), 32'(px[4]));
    check("t5_frame_pixels", 32'(fd_pix_at(fd_base)), 32'd5);
    check("t5_frame_err", 32'(fd_err_at(fd_base)), 32'd1);

    // 60-cycle high pulse
    fd_base = fd_pix.size();
    send_bit(60, 20);
    check("t6_timing_err", 32'(timing_err), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    idle(2600);
    check("t6_no_frame", 32'(fd_pix.size() - fd_base), 32'd0);

    // reset during bit 12
    for (int i = 0; i < 11; i++) send_bit(35, 30);
    neo = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t7_rst_data", 32'(pixel_data), 32'h0);
    check("t7_rst_index", 32'(pixel_index), 32'h0);
    check("t7_rst_pixels", 32'(frame_pixels), 32'h0);
    check("t7_rst_timing_err", 32'(timing_err), 32'h0);
    check("t7_rst_busy", 32'(busy), 32'h0);
    neo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pv_base = pv_data.size();
    fd_base = fd_pix.size();
    idle(1000);
    send_pixel(24'h00FF00);
    idle(100);
    check("t7_no_decode", 32'(pv_data.size() - pv_base), 32'd0);
    check("t7_not_busy", 32'(busy), 32'd0);
    idle(2510);
    send_pixel(24'h5A5A5A);
    idle(2510);
    check("t7_strobes", 32'(pv_data.size() - pv_base), 32'd1);
    check("t7_data", 32'(pv_data_at(pv_base)), 32'h5A5A5A);
    check("t7_frames", 32'(fd_pix.size() - fd_base), 32'd1);
    check("t7_frame_pixels", 32'(fd_pix_at(fd_base)), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/neo_pixel_receiver.md
NEO_PIXEL_RECEIVER -- requirements
Module: neo_pixel_receiver

Interface
REQ-001 The block SHALL have these parameters: NUM_PIXELS, 5, pixels per frame (1..7).
REQ-002 The block SHALL have these parameters: BIT_THRESH, 27, minimum high cycles decoded as a 1.
REQ-003 The block SHALL have these parameters: MIN_HIGH, 8, fewest legal high cycles.
REQ-004 The block SHALL have these parameters: MAX_HIGH, 50, high cycles at which a pulse is illegal.
REQ-005 The block SHALL have these parameters: LATCH_CYCLES, 2500, low cycles marking frame end (50 us at 50 MHz).
REQ-006 The block SHALL have these ports: clock in 1, 50 MHz system clock.
REQ-007 The block SHALL have these ports: reset in 1, asynchronous, active-low.
REQ-008 The block SHALL have these ports: neo_in in 1, asynchronous serial line.
REQ-009 The block SHALL have these ports: pixel_data out 24, decoded {G,R,B} word.
REQ-010 The block SHALL have these ports: pixel_index out 3, index of pixel_data.
REQ-011 The block SHALL have these ports: pixel_valid out 1, one-cycle strobe qualifying pixel_data and pixel_index.
REQ-012 The block SHALL have these ports: frame_done out 1, one-cycle strobe at latch detection.
REQ-013 The block SHALL have these ports: frame_pixels out 4, complete pixels received in the ended frame.
REQ-014 The block SHALL have these ports: frame_err out 1, qualified by frame_done; partial pixel or pixel overflow in that frame.
REQ-015 The block SHALL have these ports: timing_err out 1, sticky illegal-pulse flag.
REQ-016 The block SHALL have these ports: busy out 1, high while a frame is in progress (HIGH or LOW state).

Function
REQ-017 neo_in SHALL pass through a 2-flop synchronizer; all timing SHALL use the synchronized signal (sin).
REQ-018 Bit order SHALL be least-significant first: the first bit of a pixel SHALL land in pixel_data[0] and the 24th bit in pixel_data[23].
REQ-019 The FSM SHALL have the states SYNC, IDLE, HIGH, LOW and ERROR.
REQ-020 SYNC SHALL count consecutive low cycles, restarting on any high, and SHALL go to IDLE when the count reaches LATCH_CYCLES.
REQ-021 In IDLE, a rising edge of sin SHALL go to HIGH with the high counter set to 1 and the bit, pixel and frame counters zeroed.
REQ-022 In HIGH, the counter SHALL increment while sin=1.
REQ-023 In HIGH, reaching MAX_HIGH SHALL go to ERROR.
REQ-024 In HIGH, a falling edge with count<MIN_HIGH SHALL go to ERROR.
REQ-025 In HIGH, any other falling edge SHALL shift in the bit (count>=BIT_THRESH gives 1, otherwise 0) and go to LOW with the low counter set to 1.
REQ-026 In LOW, a rising edge SHALL go to HIGH (next bit, high counter set to 1).
REQ-027 In LOW, the low count reaching LATCH_CYCLES SHALL end the frame and go to IDLE.
REQ-028 When the 24th bit of a pixel is shifted, pixel_valid SHALL pulse on the following cycle if the pixel index is below NUM_PIXELS, and the bit counter SHALL wrap to 0.
REQ-029 Pixels at index NUM_PIXELS or above SHALL NOT be presented on pixel_data and SHALL set the frame's overflow condition.
REQ-030 Frame end SHALL produce a single-cycle frame_done pulse together with frame_pixels = pixels presented, saturating at NUM_PIXELS.
REQ-031 At frame end, frame_err SHALL be 1 when the bit counter is nonzero or overflow occurred.
REQ-032 ERROR SHALL set timing_err, drop any partial pixel, suppress frame_done for that frame, and behave as SYNC before returning to IDLE.
REQ-033 timing_err SHALL clear on the IDLE-to-HIGH transition of the next frame.
REQ-034 pixel_data and pixel_index SHALL hold their values between strobes.
REQ-035 Counters SHALL saturate and never wrap.
REQ-036 Latency from the synchronized falling edge of bit 24 to pixel_valid SHALL be 1 cycle.

Reset
REQ-037 When reset is asserted low, all outputs SHALL be 0 and the FSM SHALL be in SYNC.
REQ-038 Reset asserted mid-frame SHALL discard all partial state.
REQ-039 After reset release, no pixel SHALL be decoded until LATCH_CYCLES low cycles have been observed.

Verification
REQ-040 The bench SHALL cover: hold neo_in low 2500 cycles, then 24 bits (1 = 35 high/30 low, 0 = 18/40) encoding 0x00FF81, then 2500 low -> pixel_valid with pixel_data=0x00FF81 and pixel_index=0, then frame_done with frame_pixels=1 and frame_err=0.
REQ-041 The bench SHALL cover: a 5-pixel frame after sync -> five strobes with indexes 0..4 and data matching, then frame_pixels=5 and frame_err=0.
REQ-042 The bench SHALL cover: high pulses of 26 and 27 cycles -> decoded as 0 and 1 respectively.
REQ-043 The bench SHALL cover: a 5-cycle high pulse mid-pixel -> timing_err=1, no frame_done, and correct decoding of the next frame after 2500 low cycles.
REQ-044 The bench SHALL cover: 6 pixels plus 10 extra bits -> 5 strobes, then frame_pixels=5 and frame_err=1.
REQ-045 The bench SHALL cover: a 60-cycle high pulse -> ERROR.
REQ-046 The bench SHALL cover: reset pulsed low during bit 12 -> outputs 0, and no decode until 2500 low cycles have elapsed.
